isq_bank: RTL and testbench

Issue-queue storage bank for the out-of-order core. It accepts up to two renamed instructions per cycle from dispatch and holds each in a fixed slot. It presents every slot to the TPU/pdc select path as a flat line vector, and applies the per-slot wait-clear (issue) and valid-clear (free) vectors that the select path and completion logic return. It is the producer of the lines the priority decoder consumes and the consumer of its `set_inst_wat` / `set_inst_val` outputs.

---
 rtl/isq_bank.sv | 133 +++++++++++++
 tb/tb_isq_bank.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/isq_bank.sv
// Issue-queue storage bank: two-lane dispatch into fixed slots, per-slot
// issue (wat) and free (vld) clears, flat line view for the select path.
module isq_bank #(
    parameter int unsigned ISQ_DEPTH        = 64,
    parameter int unsigned INST_WIDTH       = 67,
    parameter int unsigned ISQ_IDX_BITS_NUM = 6,
    localparam int unsigned ISQ_LINE_WIDTH  = INST_WIDTH + ISQ_IDX_BITS_NUM + 2,
    localparam int unsigned CNT_W           = $clog2(ISQ_DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          dis_vld,
    input  logic [INST_WIDTH-1:0]               dis_inst0,
    input  logic [INST_WIDTH-1:0]               dis_inst1,
    output logic                                isq_rdy,
    input  logic                                flush,
    input  logic [ISQ_DEPTH-1:0]                set_inst_wat,
    input  logic [ISQ_DEPTH-1:0]                set_inst_val,
    output logic [ISQ_LINE_WIDTH*ISQ_DEPTH-1:0] isq_lin_flat,
    output logic [CNT_W-1:0]                    isq_free_cnt
);

    logic [ISQ_DEPTH-1:0]  vld;
    logic [ISQ_DEPTH-1:0]  wat;
    logic [INST_WIDTH-1:0] payload [ISQ_DEPTH];
    logic [CNT_W-1:0]      free_cnt;

    logic [ISQ_DEPTH-1:0]  first_free;
    logic [ISQ_DEPTH-1:0]  second_free;
    logic                  found_a;
    logic                  found_b;
    logic [ISQ_DEPTH-1:0]  we0;
    logic [ISQ_DEPTH-1:0]  we1;
    logic                  alloc_en;
    logic [CNT_W-1:0]      n_alloc;
    logic [CNT_W-1:0]      n_freed;

    // Ready depends only on the registered count, never on this cycle's frees
    assign isq_rdy      = (free_cnt >= CNT_W'(2));
    assign alloc_en     = isq_rdy & ~flush;
    assign isq_free_cnt = free_cnt;

    // One-hot masks of the lowest and second-lowest free slots (registered vld only)
    always_comb begin
        first_free  = '0;
        second_free = '0;
        found_a     = 1'b0;
        found_b     = 1'b0;
        for (int i = 0; i < int'(ISQ_DEPTH); i++) begin
            if (!vld[i]) begin
                if (!found_a) begin
                    first_free[i] = 1'b1;
                    found_a       = 1'b1;
                end else if (!found_b) begin
                    second_free[i] = 1'b1;
                    found_b        = 1'b1;
                end
            end
        end
    end

    // Lane packing: lane 0 takes the first free slot; lane 1 takes the next one
    // if lane 0 is active, otherwise the first
    always_comb begin
        we0 = '0;
        we1 = '0;
        if (alloc_en && dis_vld[0]) begin
            we0 = first_free;
        end
        if (alloc_en && dis_vld[1]) begin
            we1 = dis_vld[0] ? second_free : first_free;
        end
    end

    assign n_alloc = alloc_en ? (CNT_W'(dis_vld[0]) + CNT_W'(dis_vld[1])) : '0;

    // Frees only count for slots that were actually valid
    always_comb begin
        n_freed = '0;
        for (int i = 0; i < int'(ISQ_DEPTH); i++) begin
            n_freed = n_freed + CNT_W'(vld[i] & set_inst_val[i]);
        end
    end

    // Slot status: flush wins; allocation targets only free slots so it wins over clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            wat <= '0;
        end else if (flush) begin
            vld <= '0;
            wat <= '0;
        end else begin
            vld <= (vld & ~set_inst_val) | we0 | we1;
            wat <= (wat & ~set_inst_wat & ~set_inst_val) | we0 | we1;
        end
    end

    // Payload storage; retained across free and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ISQ_DEPTH); i++) begin
                payload[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(ISQ_DEPTH); i++) begin
                if (we0[i]) begin
                    payload[i] <= dis_inst0;
                end else if (we1[i]) begin
                    payload[i] <= dis_inst1;
                end
            end
        end
    end

    // Free-slot counter tracked incrementally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_cnt <= CNT_W'(ISQ_DEPTH);
        end else if (flush) begin
            free_cnt <= CNT_W'(ISQ_DEPTH);
        end else begin
            free_cnt <= free_cnt + n_freed - n_alloc;
        end
    end

    // Flat line view: {idx, vld, wat, payload} per slot
    for (genvar g = 0; g < int'(ISQ_DEPTH); g++) begin : g_line
        assign isq_lin_flat[g*ISQ_LINE_WIDTH +: ISQ_LINE_WIDTH] =
            {ISQ_IDX_BITS_NUM'(g), vld[g], wat[g], payload[g]};
    end

endmodule

// File: tb/tb_isq_bank.sv
// Directed bench for isq_bank with a reference model and a line scoreboard.
module tb_isq_bank;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned IW    = 67;
    localparam int unsigned IB    = 6;
    localparam int unsigned LW    = IW + IB + 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic                  clk;
    logic                  rst_n;
    logic [1:0]            dis_vld;
    logic [IW-1:0]         dis_inst0;
    logic [IW-1:0]         dis_inst1;
    logic                  isq_rdy;
    logic                  flush;
    logic [DEPTH-1:0]      set_inst_wat;
    logic [DEPTH-1:0]      set_inst_val;
    logic [LW*DEPTH-1:0]   isq_lin_flat;
    logic [CW-1:0]         isq_free_cnt;

    isq_bank #(
        .ISQ_DEPTH       (DEPTH),
        .INST_WIDTH      (IW),
        .ISQ_IDX_BITS_NUM(IB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dis_vld     (dis_vld),
        .dis_inst0   (dis_inst0),
        .dis_inst1   (dis_inst1),
        .isq_rdy     (isq_rdy),
        .flush       (flush),
        .set_inst_wat(set_inst_wat),
        .set_inst_val(set_inst_val),
        .isq_lin_flat(isq_lin_flat),
        .isq_free_cnt(isq_free_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [DEPTH-1:0] m_vld;
    logic [DEPTH-1:0] m_wat;
    logic [IW-1:0]    m_pay [DEPTH];

    typedef struct {
        int          slot;
        logic [LW-1:0] line;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [LW-1:0] mline(int i);
        return {IB'(i), m_vld[i], m_wat[i], m_pay[i]};
    endfunction

    function automatic logic [LW*DEPTH-1:0] mflat();
        logic [LW*DEPTH-1:0] r;
        for (int i = 0; i < int'(DEPTH); i++) r[i*LW +: LW] = mline(i);
        return r;
    endfunction

    function automatic int mfree();
        int n = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (!m_vld[i]) n++;
        return n;
    endfunction

    function automatic logic [IW-1:0] rnd();
        return IW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flat(input string tag);
        logic [LW*DEPTH-1:0] e;
        int bad;
        e = mflat();
        checks++;
        assert (isq_lin_flat === e) else begin
            errors++;
            bad = 0;
            for (int i = DEPTH - 1; i >= 0; i--)
                if (isq_lin_flat[i*LW +: LW] !== e[i*LW +: LW]) bad = i;
            $error("FAIL %s slot %0d observed=%0h expected=%0h", tag, bad,
                   isq_lin_flat[bad*LW +: LW], e[bad*LW +: LW]);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t x;
        chk({tag, "_cnt"}, 128'(isq_free_cnt), 128'(mfree()));
        chk({tag, "_rdy"}, 128'(isq_rdy), 128'(mfree() >= 2));
        chk_flat({tag, "_flat"});
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk($sformatf("%s_sb_slot%0d", tag, x.slot),
                128'(isq_lin_flat[x.slot*LW +: LW]), 128'(x.line));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_vld = '0;
        m_wat = '0;
        for (int i = 0; i < int'(DEPTH); i++) m_pay[i] = '0;
        sb.delete();
    endtask

    task automatic idle_inputs();
        dis_vld      = 2'b00;
        dis_inst0    = '0;
        dis_inst1    = '0;
        flush        = 1'b0;
        set_inst_wat = '0;
        set_inst_val = '0;
    endtask

    // Apply one cycle of stimulus, advance the model and push expected lines
    task automatic drive(input string tag, input logic [1:0] dv, input logic [IW-1:0] a,
                         input logic [IW-1:0] b, input logic [DEPTH-1:0] sw,
                         input logic [DEPTH-1:0] sv, input logic fl);
        int freeq[$];
        int s0, s1;
        bit do_alloc;
        s0 = -1;
        s1 = -1;
        if (dv != 2'b00 && !fl) chk({tag, "_rdy_at_dispatch"}, 128'(isq_rdy), 128'(1));
        dis_vld      = dv;
        dis_inst0    = a;
        dis_inst1    = b;
        set_inst_wat = sw;
        set_inst_val = sv;
        flush        = fl;
        for (int i = 0; i < int'(DEPTH); i++) if (!m_vld[i]) freeq.push_back(i);
        do_alloc = (freeq.size() >= 2) && !fl;
        if (fl) begin
            m_vld = '0;
            m_wat = '0;
        end else begin
            m_wat = m_wat & ~sw & ~sv;
            m_vld = m_vld & ~sv;
            if (do_alloc) begin
                if (dv[0]) s0 = freeq[0];
                if (dv[1]) s1 = dv[0] ? freeq[1] : freeq[0];
                if (s0 >= 0) begin m_vld[s0] = 1'b1; m_wat[s0] = 1'b1; m_pay[s0] = a; end
                if (s1 >= 0) begin m_vld[s1] = 1'b1; m_wat[s1] = 1'b1; m_pay[s1] = b; end
            end
        end
        if (s0 >= 0) sb.push_back('{slot: s0, line: mline(s0)});
        if (s1 >= 0) sb.push_back('{slot: s1, line: mline(s1)});
        tick();
        idle_inputs();
        check_all(tag);
    endtask

    logic [IW-1:0] pa, pb, pc, pd, pe;
    logic [CW-1:0] cnt_before;

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cnt", 128'(isq_free_cnt), 128'(64));
        chk("reset_rdy", 128'(isq_rdy), 128'(1));
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Dual dispatch right after reset
        pa = rnd();
        pb = rnd();
        drive("dual", 2'b11, pa, pb, '0, '0, 1'b0);
        chk("dual_slot0", 128'(isq_lin_flat[0*LW +: LW]), 128'({6'd0, 1'b1, 1'b1, pa}));
        chk("dual_slot1", 128'(isq_lin_flat[1*LW +: LW]), 128'({6'd1, 1'b1, 1'b1, pb}));
        chk("dual_cnt", 128'(isq_free_cnt), 128'(62));

        // Fill to 62 valid, then to full
        for (int k = 0; k < 30; k++) drive("fill", 2'b11, rnd(), rnd(), '0, '0, 1'b0);
        chk("at62_cnt", 128'(isq_free_cnt), 128'(2));
        chk("at62_rdy", 128'(isq_rdy), 128'(1));
        drive("full", 2'b11, rnd(), rnd(), '0, '0, 1'b0);
        chk("full_cnt", 128'(isq_free_cnt), 128'(0));
        chk("full_rdy", 128'(isq_rdy), 128'(0));
        drive("free0", 2'b00, '0, '0, '0, DEPTH'(1) << 0, 1'b0);
        chk("free1_cnt", 128'(isq_free_cnt), 128'(1));
        chk("free1_rdy", 128'(isq_rdy), 128'(0));
        drive("free2", 2'b00, '0, '0, '0, DEPTH'(1) << 2, 1'b0);
        chk("free2_cnt", 128'(isq_free_cnt), 128'(2));
        chk("free2_rdy", 128'(isq_rdy), 128'(1));

        // Lane-1-only dispatch fills the lowest hole
        pc = rnd();
        drive("lane1", 2'b10, '0, pc, '0, '0, 1'b0);
        chk("lane1_slot0", 128'(isq_lin_flat[0*LW +: LW]), 128'({6'd0, 1'b1, 1'b1, pc}));
        chk("lane1_slot2_vld", 128'(isq_lin_flat[2*LW + IW + 1]), 128'(0));
        chk("lane1_cnt", 128'(isq_free_cnt), 128'(1));

        // Issue then free slot 5
        drive("issue5", 2'b00, '0, '0, DEPTH'(1) << 5, '0, 1'b0);
        chk("issue5_wat", 128'(isq_lin_flat[5*LW + IW]), 128'(0));
        chk("issue5_vld", 128'(isq_lin_flat[5*LW + IW + 1]), 128'(1));
        drive("gap1", 2'b00, '0, '0, '0, '0, 1'b0);
        drive("gap2", 2'b00, '0, '0, '0, '0, 1'b0);
        drive("free5", 2'b00, '0, '0, '0, DEPTH'(1) << 5, 1'b0);
        chk("free5_vld", 128'(isq_lin_flat[5*LW + IW + 1]), 128'(0));
        chk("free5_cnt", 128'(isq_free_cnt), 128'(2));

        // Dispatch with a same-cycle free of slot 3: new work lands in 2 and 5
        pd = rnd();
        pe = rnd();
        drive("simul", 2'b11, pd, pe, '0, DEPTH'(1) << 3, 1'b0);
        chk("simul_slot2", 128'(isq_lin_flat[2*LW +: LW]), 128'({6'd2, 1'b1, 1'b1, pd}));
        chk("simul_slot5", 128'(isq_lin_flat[5*LW +: LW]), 128'({6'd5, 1'b1, 1'b1, pe}));
        chk("simul_slot3_vld", 128'(isq_lin_flat[3*LW + IW + 1]), 128'(0));
        chk("simul_cnt", 128'(isq_free_cnt), 128'(1));
        cnt_before = isq_free_cnt;
        drive("inv_free", 2'b00, '0, '0, '0, DEPTH'(1) << 3, 1'b0);
        chk("inv_free_cnt", 128'(isq_free_cnt), 128'(1));

        // Both clears on slot 7 together
        drive("both7", 2'b00, '0, '0, DEPTH'(1) << 7, DEPTH'(1) << 7, 1'b0);
        chk("both7_vw", 128'(isq_lin_flat[7*LW + IW +: 2]), 128'(0));
        chk("both7_cnt", 128'(isq_free_cnt), 128'(2));

        // Flush beats dispatch and set vectors
        drive("flush", 2'b11, rnd(), rnd(), DEPTH'(1) << 9, DEPTH'(1) << 10, 1'b1);
        chk("flush_cnt", 128'(isq_free_cnt), 128'(64));
        chk("flush_vld0", 128'(isq_lin_flat[0*LW + IW + 1]), 128'(0));

        // Refill a bit, then hit reset between edges
        drive("post_flush", 2'b11, rnd(), rnd(), '0, '0, 1'b0);
        chk("post_flush_cnt", 128'(isq_free_cnt), 128'(62));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_cnt", 128'(isq_free_cnt), 128'(64));
        chk("async_rdy", 128'(isq_rdy), 128'(1));
        check_all("async");
        #1;
        rst_n = 1'b1;
        drive("after_rst", 2'b11, rnd(), rnd(), '0, '0, 1'b0);
        chk("after_rst_cnt", 128'(isq_free_cnt), 128'(62));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
